// File: rtl/hazard_ctrl_unit.sv
// hazard_ctrl_unit
//   Pipeline hazard controller for the 5-stage MIPS core. It detects load-use
//   hazards (ID against EX), taken branches resolved in MEM, and data-memory
//   wait states, then drives the stall/flush controls of the pipeline registers.
//   Control outputs are combinational from the registered state and the current
//   inputs, so the pipeline registers act on them at the same posedge.
//
// Parameters
//   LOAD_STALL_CYCLES  bubbles per load-use hazard (1..3)
//   MEM_TIMEOUT        consecutive dmem_busy cycles before mem_timeout_err sets (2..255)
//
// Optional feature
//   HAZARD_PERF_EN     when defined, perf_stall_cnt / perf_flush_cnt count stall
//                      cycles and taken-branch flushes; otherwise both are tied to 0.
//
// Ports
//   clk, rst                    clock (posedge), asynchronous active-high reset
//   id_rs, id_rt, id_uses_rt    source registers of the instruction in ID
//   ex_memread, ex_rt           load indication and destination of the instruction in EX
//   mem_branch, mem_zero        branch resolution in MEM
//   dmem_busy                   data memory not ready
//   *_write_en                  pipeline register / PC enables (hold when 0)
//   ifid_flush, idex_ctrl_flush, idex_beq_flush, exmem_flush, memwb_bubble
//                               pipeline register clears / bubbles
//   mem_timeout_err             sticky memory watchdog flag
//   perf_stall_cnt, perf_flush_cnt  performance counters
module hazard_ctrl_unit #(
  parameter int unsigned LOAD_STALL_CYCLES = 1,
  parameter int unsigned MEM_TIMEOUT       = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_uses_rt,
  input  logic        ex_memread,
  input  logic [4:0]  ex_rt,
  input  logic        mem_branch,
  input  logic        mem_zero,
  input  logic        dmem_busy,
  output logic        pc_write_en,
  output logic        ifid_write_en,
  output logic        ifid_flush,
  output logic        idex_write_en,
  output logic        idex_ctrl_flush,
  output logic        idex_beq_flush,
  output logic        exmem_write_en,
  output logic        exmem_flush,
  output logic        memwb_bubble,
  output logic        mem_timeout_err,
  output logic [31:0] perf_stall_cnt,
  output logic [31:0] perf_flush_cnt
);

  localparam int unsigned SCNT_W = 2;
  localparam int unsigned WCNT_W = 8;
  localparam logic [SCNT_W-1:0] SCNT_INIT   = SCNT_W'(LOAD_STALL_CYCLES - 1);
  localparam logic [WCNT_W-1:0] WCNT_LIMIT  = WCNT_W'(MEM_TIMEOUT - 1);
  localparam logic              MULTI_STALL = (LOAD_STALL_CYCLES > 1);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    LDSTALL = 2'd1,
    MEMWAIT = 2'd2
  } state_t;

  state_t              state, stateNext, effState;
  logic [SCNT_W-1:0]   scnt, scntNext;
  logic [WCNT_W-1:0]   wcnt, wcntNext;
  logic                errNext;
  logic                takenBranch;
  logic                loadUse;

  assign takenBranch = mem_branch & mem_zero;
  assign loadUse     = ex_memread & (ex_rt != 5'd0) &
                       ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt)));

  // State, stall counter, watchdog and sticky error registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= RUN;
      scnt            <= '0;
      wcnt            <= '0;
      mem_timeout_err <= 1'b0;
    end else begin
      state           <= stateNext;
      scnt            <= scntNext;
      wcnt            <= wcntNext;
      mem_timeout_err <= errNext;
    end
  end

  // Next-state and control outputs
  always_comb begin
    // Leaving MEMWAIT resumes whatever the stall counter says was pending
    effState = state;
    if (state == MEMWAIT) effState = (scnt != '0) ? LDSTALL : RUN;

    stateNext       = effState;
    scntNext        = scnt;
    wcntNext        = '0;
    errNext         = mem_timeout_err;
    pc_write_en     = 1'b1;
    ifid_write_en   = 1'b1;
    ifid_flush      = 1'b0;
    idex_write_en   = 1'b1;
    idex_ctrl_flush = 1'b0;
    idex_beq_flush  = 1'b0;
    exmem_write_en  = 1'b1;
    exmem_flush     = 1'b0;
    memwb_bubble    = 1'b0;

    if (dmem_busy) begin
      // Freeze everything upstream of MEM; scnt is held for later
      pc_write_en    = 1'b0;
      ifid_write_en  = 1'b0;
      idex_write_en  = 1'b0;
      exmem_write_en = 1'b0;
      memwb_bubble   = 1'b1;
      stateNext      = MEMWAIT;
      wcntNext       = (wcnt == '1) ? wcnt : wcnt + WCNT_W'(1);
      if (wcnt >= WCNT_LIMIT) errNext = 1'b1;
    end else if (takenBranch) begin
      // Squash the three wrong-path instructions; cancels any pending stall
      ifid_flush     = 1'b1;
      idex_beq_flush = 1'b1;
      exmem_flush    = 1'b1;
      stateNext      = RUN;
      scntNext       = '0;
    end else if (effState == LDSTALL) begin
      pc_write_en     = 1'b0;
      ifid_write_en   = 1'b0;
      idex_ctrl_flush = 1'b1;
      scntNext        = scnt - SCNT_W'(1);
      stateNext       = (scnt <= SCNT_W'(1)) ? RUN : LDSTALL;
    end else if (loadUse) begin
      pc_write_en     = 1'b0;
      ifid_write_en   = 1'b0;
      idex_ctrl_flush = 1'b1;
      scntNext        = SCNT_INIT;
      stateNext       = MULTI_STALL ? LDSTALL : RUN;
    end

    // Hold every pipeline register quiet while reset is asserted
    if (rst) begin
      pc_write_en     = 1'b0;
      ifid_write_en   = 1'b0;
      ifid_flush      = 1'b0;
      idex_write_en   = 1'b0;
      idex_ctrl_flush = 1'b0;
      idex_beq_flush  = 1'b0;
      exmem_write_en  = 1'b0;
      exmem_flush     = 1'b0;
      memwb_bubble    = 1'b0;
    end
  end

`ifdef HAZARD_PERF_EN
  logic [31:0] stallCnt;
  logic [31:0] flushCnt;

  // Performance counters; both wrap naturally at 2^32
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stallCnt <= 32'd0;
      flushCnt <= 32'd0;
    end else begin
      if (!pc_write_en) stallCnt <= stallCnt + 32'd1;
      if (ifid_flush)   flushCnt <= flushCnt + 32'd1;
    end
  end

  assign perf_stall_cnt = stallCnt;
  assign perf_flush_cnt = flushCnt;
`else
  assign perf_stall_cnt = 32'd0;
  assign perf_flush_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// tb_hazard_ctrl_unit
//   Directed bench for hazard_ctrl_unit. Instance A uses LOAD_STALL_CYCLES=1,
//   MEM_TIMEOUT=64; instance B uses LOAD_STALL_CYCLES=2, MEM_TIMEOUT=4. Both share
//   the input stimulus. Control outputs are packed as
//   {pc_we, ifid_we, ifid_flush, idex_we, idex_ctrl_flush, idex_beq_flush,
//    exmem_we, exmem_flush, memwb_bubble}.
module tb_hazard_ctrl_unit;

  localparam logic [8:0] C_IDLE   = 9'b1_1_0_1_0_0_1_0_0;
  localparam logic [8:0] C_STALL  = 9'b0_0_0_1_1_0_1_0_0;
  localparam logic [8:0] C_BRANCH = 9'b1_1_1_1_0_1_1_1_0;
  localparam logic [8:0] C_FREEZE = 9'b0_0_0_0_0_0_0_0_1;
  localparam logic [8:0] C_RESET  = 9'b0_0_0_0_0_0_0_0_0;

`ifdef HAZARD_PERF_EN
  localparam bit PERF_EN = 1'b1;
`else
  localparam bit PERF_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic [4:0] idRs, idRt, exRt;
  logic idUsesRt, exMemread, memBranch, memZero, dmemBusy;

  logic pcA, ifidWeA, ifidFlA, idexWeA, idexCfA, idexBfA, exmemWeA, exmemFlA, bubA, errA;
  logic pcB, ifidWeB, ifidFlB, idexWeB, idexCfB, idexBfB, exmemWeB, exmemFlB, bubB, errB;
  logic [31:0] stallCntA, flushCntA, stallCntB, flushCntB;
  logic [8:0] ctrlA, ctrlB;

  int nChecks = 0;
  int nFails  = 0;

  always #5 clk = ~clk;

  assign ctrlA = {pcA, ifidWeA, ifidFlA, idexWeA, idexCfA, idexBfA, exmemWeA, exmemFlA, bubA};
  assign ctrlB = {pcB, ifidWeB, ifidFlB, idexWeB, idexCfB, idexBfB, exmemWeB, exmemFlB, bubB};

  hazard_ctrl_unit #(.LOAD_STALL_CYCLES(1), .MEM_TIMEOUT(64)) dutA (
    .clk(clk), .rst(rst), .id_rs(idRs), .id_rt(idRt), .id_uses_rt(idUsesRt),
    .ex_memread(exMemread), .ex_rt(exRt), .mem_branch(memBranch), .mem_zero(memZero),
    .dmem_busy(dmemBusy), .pc_write_en(pcA), .ifid_write_en(ifidWeA), .ifid_flush(ifidFlA),
    .idex_write_en(idexWeA), .idex_ctrl_flush(idexCfA), .idex_beq_flush(idexBfA),
    .exmem_write_en(exmemWeA), .exmem_flush(exmemFlA), .memwb_bubble(bubA),
    .mem_timeout_err(errA), .perf_stall_cnt(stallCntA), .perf_flush_cnt(flushCntA)
  );

  hazard_ctrl_unit #(.LOAD_STALL_CYCLES(2), .MEM_TIMEOUT(4)) dutB (
    .clk(clk), .rst(rst), .id_rs(idRs), .id_rt(idRt), .id_uses_rt(idUsesRt),
    .ex_memread(exMemread), .ex_rt(exRt), .mem_branch(memBranch), .mem_zero(memZero),
    .dmem_busy(dmemBusy), .pc_write_en(pcB), .ifid_write_en(ifidWeB), .ifid_flush(ifidFlB),
    .idex_write_en(idexWeB), .idex_ctrl_flush(idexCfB), .idex_beq_flush(idexBfB),
    .exmem_write_en(exmemWeB), .exmem_flush(exmemFlB), .memwb_bubble(bubB),
    .mem_timeout_err(errB), .perf_stall_cnt(stallCntB), .perf_flush_cnt(flushCntB)
  );

  typedef struct {
    string      name;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       usesRt;
    logic       memread;
    logic [4:0] exRt;
    logic       branch;
    logic       zero;
    logic       busy;
    logic [8:0] exp;
  } vec_t;

  vec_t vecs[13];

  function automatic vec_t mk(input string name, input logic [4:0] rs, input logic [4:0] rt,
                              input logic usesRt, input logic memread, input logic [4:0] exRt,
                              input logic branch, input logic zero, input logic busy,
                              input logic [8:0] exp);
    vec_t v;
    v.name = name; v.rs = rs; v.rt = rt; v.usesRt = usesRt; v.memread = memread;
    v.exRt = exRt; v.branch = branch; v.zero = zero; v.busy = busy; v.exp = exp;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic setIn(input logic [4:0] rs, input logic [4:0] rt, input logic usesRt,
                       input logic memread, input logic [4:0] xRt, input logic branch,
                       input logic zero, input logic busy);
    idRs = rs; idRt = rt; idUsesRt = usesRt; exMemread = memread; exRt = xRt;
    memBranch = branch; memZero = zero; dmemBusy = busy;
  endtask

  task automatic setIdle();
    setIn(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic pulseReset();
    rst = 1'b1;
    nextCycle();
    rst = 1'b0;
  endtask

  // Global bound so the run always terminates
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "bench timeout");
  end

  initial begin
    int expStall = 0;
    int expFlush = 0;

    vecs[0]  = mk("ldUseRs",         5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, C_STALL);
    vecs[1]  = mk("afterLdUse",      5'd5, 5'd0, 1'b0, 1'b0, 5'd5, 1'b0, 1'b0, 1'b0, C_IDLE);
    vecs[2]  = mk("ldUseRt",         5'd3, 5'd7, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, C_STALL);
    vecs[3]  = mk("rtNotUsed",       5'd3, 5'd7, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, C_IDLE);
    vecs[4]  = mk("exRtZero",        5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, C_IDLE);
    vecs[5]  = mk("noMemread",       5'd9, 5'd9, 1'b1, 1'b0, 5'd9, 1'b0, 1'b0, 1'b0, C_IDLE);
    vecs[6]  = mk("branchOverLdUse", 5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, C_BRANCH);
    vecs[7]  = mk("notTakenLdUse",   5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, C_STALL);
    vecs[8]  = mk("zeroNoBranch",    5'd1, 5'd2, 1'b1, 1'b0, 5'd3, 1'b0, 1'b1, 1'b0, C_IDLE);
    vecs[9]  = mk("busyOverAll",     5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1, 1'b1, C_FREEZE);
    vecs[10] = mk("busyAlone",       5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, C_FREEZE);
    vecs[11] = mk("ldUseAfterBusy",  5'd4, 5'd8, 1'b1, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, C_STALL);
    vecs[12] = mk("idleEnd",         5'd4, 5'd8, 1'b1, 1'b0, 5'd8, 1'b0, 1'b0, 1'b0, C_IDLE);

    // Reset state
    rst = 1'b1;
    setIdle();
    @(negedge clk);
    check("resetCtrlA", 32'(ctrlA), 32'(C_RESET));
    check("resetCtrlB", 32'(ctrlB), 32'(C_RESET));
    check("resetErrA", 32'(errA), 32'd0);
    check("resetStallCntA", stallCntA, 32'd0);
    check("resetFlushCntA", flushCntA, 32'd0);
    nextCycle();
    rst = 1'b0;

    // Table-driven vectors against instance A (single-cycle load-use stall)
    for (int i = 0; i < 13; i++) begin
      setIn(vecs[i].rs, vecs[i].rt, vecs[i].usesRt, vecs[i].memread, vecs[i].exRt,
            vecs[i].branch, vecs[i].zero, vecs[i].busy);
      @(negedge clk);
      check(vecs[i].name, 32'(ctrlA), 32'(vecs[i].exp));
      if (!vecs[i].exp[8]) expStall++;
      if (vecs[i].exp[6])  expFlush++;
      nextCycle();
    end
    setIdle();
    @(negedge clk);
    check("perfStallA", stallCntA, PERF_EN ? 32'(expStall) : 32'd0);
    check("perfFlushA", flushCntA, PERF_EN ? 32'(expFlush) : 32'd0);
    check("errA", 32'(errA), 32'd0);
    nextCycle();

    // Two-cycle load-use stall with ex_memread dropping after the first cycle
    pulseReset();
    setIn(5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
    @(negedge clk); check("ls2Stall1", 32'(ctrlB), 32'(C_STALL)); nextCycle();
    setIn(5'd5, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk); check("ls2Stall2", 32'(ctrlB), 32'(C_STALL)); nextCycle();
    @(negedge clk); check("ls2Run", 32'(ctrlB), 32'(C_IDLE)); nextCycle();

    // Taken branch together with a load-use hazard: flush, no stall afterwards
    setIn(5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0);
    @(negedge clk); check("brLdUse", 32'(ctrlB), 32'(C_BRANCH)); nextCycle();
    setIdle();
    @(negedge clk); check("brNoStall", 32'(ctrlB), 32'(C_IDLE)); nextCycle();

    // Taken branch cancels a pending second stall cycle
    setIn(5'd6, 5'd0, 1'b0, 1'b1, 5'd6, 1'b0, 1'b0, 1'b0);
    @(negedge clk); check("cancelStall", 32'(ctrlB), 32'(C_STALL)); nextCycle();
    setIn(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0);
    @(negedge clk); check("cancelBranch", 32'(ctrlB), 32'(C_BRANCH)); nextCycle();
    setIdle();
    @(negedge clk); check("cancelRun", 32'(ctrlB), 32'(C_IDLE)); nextCycle();

    // Memory wait during LDSTALL preserves the pending stall cycle
    setIn(5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
    @(negedge clk); check("mwStall", 32'(ctrlB), 32'(C_STALL)); nextCycle();
    for (int i = 0; i < 3; i++) begin
      setIn(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
      @(negedge clk); check("mwFreeze", 32'(ctrlB), 32'(C_FREEZE)); nextCycle();
    end
    setIdle();
    @(negedge clk);
    check("mwResumeStall", 32'(ctrlB), 32'(C_STALL));
    check("mwNoErr", 32'(errB), 32'd0);
    nextCycle();
    @(negedge clk); check("mwRun", 32'(ctrlB), 32'(C_IDLE)); nextCycle();

    // Watchdog: four busy cycles set the sticky error
    for (int i = 0; i < 4; i++) begin
      setIn(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
      @(negedge clk); check("wdErrLow", 32'(errB), 32'd0); nextCycle();
    end
    setIdle();
    @(negedge clk);
    check("wdErrSet", 32'(errB), 32'd1);
    check("wdRunAfter", 32'(ctrlB), 32'(C_IDLE));
    nextCycle();
    @(negedge clk); check("wdErrSticky", 32'(errB), 32'd1); nextCycle();

    // Reset pulse in the middle of a memory wait
    setIn(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    nextCycle();
    rst = 1'b1;
    @(negedge clk);
    check("rstMidCtrl", 32'(ctrlB), 32'(C_RESET));
    check("rstMidErr", 32'(errB), 32'd0);
    nextCycle();
    rst = 1'b0;
    setIdle();
    @(negedge clk); check("rstRelease", 32'(ctrlB), 32'(C_IDLE)); nextCycle();
    setIn(5'd2, 5'd0, 1'b0, 1'b1, 5'd2, 1'b0, 1'b0, 1'b0);
    @(negedge clk); check("rstThenLdUse", 32'(ctrlB), 32'(C_STALL)); nextCycle();

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
